layer_line_reader: RTL and testbench
====================================

// Module: layer_line_reader
// PURPOSE
//  Composer-side reader for one layer's double-buffered line buffer. On each line_start it toggles
//  the render/compose buffer select and walks composer_rd_idx across the line with fractional
//  horizontal scaling, absorbing the buffer's 1-cycle read latency. It delivers a valid/ready pixel
//  stream to the composer; the renderer fills the other buffer in parallel.
// PARAMETERS
//  IDX_W    10   line-buffer index width (covers 0..767 valid, 768..1023 out of range)
//  FRAC_W   7    fractional bits of scale accumulator (hscale 128 = 1 output px per buffer px)
//  FIFO_D   2    output skid FIFO depth (power of 2, >=2)
// PORTS
//  clk                  in   1   system clock
//  rst_n                in   1   synchronous reset, active low
//  line_start           in   1   pulse: begin new active line
//  line_width           in   10  output pixels this line, sampled at line_start (0 = none)
//  hstart               in   10  first buffer index, sampled at line_start
//  hscale               in   8   per-pixel index increment, 1.7 fixed point, sampled at line_start
//  mirror               in   1   reverse walk direction (LINE_READER_MIRROR_EN only)
//  active_render_buffer out  1   buffer select to line buffer; composer side is its inverse
//  composer_rd_idx      out  10  read index to line buffer
//  composer_rd_data     in   8   read data, valid 1 cycle after composer_rd_idx
//  pix_data             out  8   pixel to composer (0 when index out of range)
//  pix_valid            out  1   pix_data valid
//  pix_ready            in   1   composer accepts pixel when pix_valid & pix_ready
//  line_done            out  1   1-cycle pulse when last pixel of the line is accepted
// BEHAVIOUR
//  - Reset: active_render_buffer=0, composer_rd_idx=0, pix_valid=0, pix_data=0, line_done=0, FSM IDLE, FIFO empty.
//  - FSM IDLE -> RUN on line_start if line_width!=0; RUN -> DRAIN when line_width reads issued;
//    DRAIN -> IDLE when FIFO empty and last pixel accepted (line_done pulses in that cycle).
//  - Every line_start (any state): toggle active_render_buffer next cycle; in RUN/DRAIN also abort:
//    flush FIFO, drop in-flight read, no line_done, restart with new parameters (IDLE if width 0).
//  - Accumulator acc[IDX_W+FRAC_W-1:0] = {hstart,0} at start; after each issue acc += hscale
//    (acc -= hscale when mirrored); wraps modulo 2^17. composer_rd_idx = acc[16:7].
//  - Issue rule: one read per cycle while RUN and (FIFO occupancy + in-flight) < FIFO_D.
//  - Data registered into FIFO 1 cycle after issue; idx[9:8]==2'b11 flag is pipelined alongside,
//    and when set the FIFO entry is 0 instead of composer_rd_data.
//  - Latency line_start -> first pix_valid: 3 cycles with pix_ready held high; then 1 px/clk.
//  - pix_ready low: pix_data/pix_valid held stable; issue stalls; no pixel lost or duplicated.
//  - hscale 0: same index repeated line_width times (legal). line_start with line_done same cycle: line_done wins, then restart.
// CONFIGURATION
//  LINE_READER_MIRROR_EN defined: mirror sampled at line_start; 1 -> accumulator decrements from hstart.
//  Undefined: mirror port present but ignored; walk always increments.
// STRUCTURE
//  Shared header video_defs.vh: IDX_W, FRAC_W, LINEBUF_LIMIT (768), HSCALE_UNITY (128), FSM state encodings.
//  Sub-module: pixel_skid_fifo (FIFO_D x 8-bit sync FIFO, flush input, valid/ready out).
//  Top: FSM, accumulator, pixel counter, in-flight/range pipeline flags.
// TESTING
//  1. hstart=0, hscale=128, width=4, ready=1 -> rd_idx 0,1,2,3; pix_data=mem[0..3] back-to-back; line_done on 4th.
//  2. hscale=64, hstart=10, width=4 -> rd_idx 10,10,11,11; pixels mem[10],mem[10],mem[11],mem[11].
//  3. hstart=766, hscale=128, width=4 -> idx 766,767,768,769; pixels mem[766],mem[767],0,0.
//  4. pix_ready toggled 1/0 pseudo-randomly, width=640 -> exactly 640 pixels, in order, data stable while stalled.
//  5. line_start mid-line after 100 px -> FIFO flushed, no line_done, buffer select toggles, new line from new hstart.
//  6. rst_n low mid-line -> all outputs at reset values next cycle; MIRROR_EN: hstart=5,width=3 -> idx 5,4,3.

Source files
------------

// File: rtl/layer_line_reader_pkg.sv
// Shared constants and FSM encoding for the composer-side line-buffer reader.
package layer_line_reader_pkg;

  localparam int DEF_IDX_W     = 10;
  localparam int DEF_FRAC_W    = 7;
  localparam int DEF_FIFO_D    = 2;
  localparam int LINEBUF_LIMIT = 768;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_e;

endpackage

// File: rtl/layer_line_reader_skid_fifo.sv
// pixel_skid_fifo: small synchronous FIFO with synchronous flush and valid/ready read side.
module pixel_skid_fifo #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush_i,
  input  logic                        push_i,
  input  logic [DATA_W-1:0]           data_i,
  input  logic                        ready_i,
  output logic                        valid_o,
  output logic [DATA_W-1:0]           data_o,
  output logic [$clog2(DEPTH):0]      count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]    count_q;
  logic              push_ok, pop;

  assign valid_o = (count_q != '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign pop     = valid_o & ready_i;
  assign push_ok = push_i & (count_q != FULL);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop);
    end
  end

endmodule

// File: rtl/layer_line_reader.sv
// Composer-side reader for a double-buffered line buffer with fractional horizontal scaling.
// Optional reverse walk enabled by defining LINE_READER_MIRROR_EN.
//
// state | meaning
// IDLE  | no active line, waiting for line_start
// RUN   | issuing buffer reads, one per cycle when FIFO credit allows
// DRAIN | all reads issued, waiting for composer to take the remaining pixels
module layer_line_reader
  import layer_line_reader_pkg::*;
#(
  parameter int IDX_W  = DEF_IDX_W,
  parameter int FRAC_W = DEF_FRAC_W,
  parameter int FIFO_D = DEF_FIFO_D
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             line_start,
  input  logic [IDX_W-1:0] line_width,
  input  logic [IDX_W-1:0] hstart,
  input  logic [7:0]       hscale,
  input  logic             mirror,
  output logic             active_render_buffer,
  output logic [IDX_W-1:0] composer_rd_idx,
  input  logic [7:0]       composer_rd_data,
  output logic [7:0]       pix_data,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic             line_done
);

  localparam int ACC_W = IDX_W + FRAC_W;
  localparam int CNT_W = $clog2(FIFO_D) + 1;

  rd_state_e        state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d, acc_step, acc_next;
  logic [7:0]       hscale_q, hscale_d;
  logic [IDX_W-1:0] issue_left_q, issue_left_d, pix_left_q, pix_left_d;
  logic             sel_q, inflight_q, inflight_d, oor_q, oor_d;
  logic             issue, pop, fifo_valid;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   credit;
  logic [7:0]       fifo_wdata;

  assign composer_rd_idx      = acc_q[ACC_W-1:FRAC_W];
  assign active_render_buffer = sel_q;
  assign pix_valid            = fifo_valid;
  assign pop                  = fifo_valid & pix_ready;
  assign acc_step             = ACC_W'(hscale_q);
  assign fifo_wdata           = oor_q ? 8'h00 : composer_rd_data;

  // A pixel leaving this cycle frees its slot in time for the next issue, keeping 1 px/clk.
  assign credit    = {1'b0, fifo_count} + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
  assign issue     = (state_q == ST_RUN) && (credit < (CNT_W+1)'(FIFO_D));
  assign line_done = pop && (state_q == ST_DRAIN) && (pix_left_q == IDX_W'(1));

`ifdef LINE_READER_MIRROR_EN
  logic mirror_q, mirror_d;
  assign acc_next = mirror_q ? (acc_q - acc_step) : (acc_q + acc_step);
`else
  logic unused_mirror;
  assign unused_mirror = mirror;
  assign acc_next      = acc_q + acc_step;
`endif

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    hscale_d     = hscale_q;
    issue_left_d = issue_left_q;
    pix_left_d   = pix_left_q;
    inflight_d   = issue;
    oor_d        = (composer_rd_idx >= IDX_W'(LINEBUF_LIMIT));
`ifdef LINE_READER_MIRROR_EN
    mirror_d     = mirror_q;
`endif
    if (issue) begin
      acc_d        = acc_next;
      issue_left_d = issue_left_q - 1'b1;
    end
    if (pop) pix_left_d = pix_left_q - 1'b1;
    case (state_q)
      ST_RUN:   if (issue && issue_left_q == IDX_W'(1)) state_d = ST_DRAIN;
      ST_DRAIN: if (line_done) state_d = ST_IDLE;
      default:  state_d = state_q;
    endcase
    // A new line aborts whatever is running; the in-flight read is dropped.
    if (line_start) begin
      state_d      = (line_width != '0) ? ST_RUN : ST_IDLE;
      acc_d        = {hstart, {FRAC_W{1'b0}}};
      hscale_d     = hscale;
      issue_left_d = line_width;
      pix_left_d   = line_width;
      inflight_d   = 1'b0;
`ifdef LINE_READER_MIRROR_EN
      mirror_d     = mirror;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      acc_q        <= '0;
      hscale_q     <= '0;
      issue_left_q <= '0;
      pix_left_q   <= '0;
      inflight_q   <= 1'b0;
      oor_q        <= 1'b0;
      sel_q        <= 1'b0;
`ifdef LINE_READER_MIRROR_EN
      mirror_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      hscale_q     <= hscale_d;
      issue_left_q <= issue_left_d;
      pix_left_q   <= pix_left_d;
      inflight_q   <= inflight_d;
      oor_q        <= oor_d;
      sel_q        <= sel_q ^ line_start;
`ifdef LINE_READER_MIRROR_EN
      mirror_q     <= mirror_d;
`endif
    end
  end

  pixel_skid_fifo #(
    .DEPTH  (FIFO_D),
    .DATA_W (8)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (line_start),
    .push_i  (inflight_q),
    .data_i  (fifo_wdata),
    .ready_i (pix_ready),
    .valid_o (fifo_valid),
    .data_o  (pix_data),
    .count_o (fifo_count)
  );

endmodule

// File: tb/tb_layer_line_reader.sv
// Directed bench for layer_line_reader: line-level pixel model plus hand-computed literals.
module tb_layer_line_reader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       line_start = 1'b0;
  logic [9:0] line_width = '0;
  logic [9:0] hstart = '0;
  logic [7:0] hscale = '0;
  logic       mirror = 1'b0;
  logic       active_render_buffer;
  logic [9:0] composer_rd_idx;
  logic [7:0] composer_rd_data = '0;
  logic [7:0] pix_data;
  logic       pix_valid;
  logic       pix_ready = 1'b1;
  logic       line_done;

  int errors = 0;
  int checks = 0;

  layer_line_reader dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .line_start           (line_start),
    .line_width           (line_width),
    .hstart               (hstart),
    .hscale               (hscale),
    .mirror               (mirror),
    .active_render_buffer (active_render_buffer),
    .composer_rd_idx      (composer_rd_idx),
    .composer_rd_data     (composer_rd_data),
    .pix_data             (pix_data),
    .pix_valid            (pix_valid),
    .pix_ready            (pix_ready),
    .line_done            (line_done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] memf(input int i);
    int t;
    t = i * 37 + 11;
    return t[7:0];
  endfunction

  // Line buffer: registered read, defined data for every index including out-of-range ones.
  always @(posedge clk) composer_rd_data <= memf(int'(composer_rd_idx));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Line-level model: each line_start fixes the full expected pixel sequence.
  logic [7:0] exp_q[$];
  bit         line_active = 0;
  bit         exp_sel = 0;
  bit         stall_pending = 0;
  logic [7:0] stall_data = '0;
  int         done_count = 0;
  int         accepted = 0;

  always @(negedge clk) begin
    bit got_done;
    int a, idx, m;
    if (!rst_n) begin
      exp_q.delete();
      line_active   = 0;
      exp_sel       = 0;
      stall_pending = 0;
    end else begin
      check("buf_sel", active_render_buffer, exp_sel);
      if (stall_pending) begin
        check("stall_valid", pix_valid, 1);
        check("stall_data", pix_data, stall_data);
      end
      got_done = 0;
      if (exp_q.size() == 0) check("idle_valid", pix_valid, 0);
      else if (pix_valid && pix_ready) begin
        check("pix_data", pix_data, exp_q.pop_front());
        accepted++;
        if (exp_q.size() == 0 && line_active) got_done = 1;
      end
      check("line_done", line_done, got_done);
      if (got_done) begin
        line_active = 0;
        done_count++;
      end
      stall_pending = pix_valid && !pix_ready && !line_start;
      stall_data    = pix_data;
      if (line_start) begin
        exp_q.delete();
`ifdef LINE_READER_MIRROR_EN
        m = mirror ? -1 : 1;
`else
        m = 1;
`endif
        for (int k = 0; k < int'(line_width); k++) begin
          a   = ((int'(hstart) << 7) + m * k * int'(hscale)) & 'h1FFFF;
          idx = a >> 7;
          exp_q.push_back(idx >= 768 ? 8'h00 : memf(idx));
        end
        exp_sel     = !exp_sel;
        accepted    = 0;
        line_active = (line_width != 0);
      end
    end
  end

  int n_starts = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_line(input int hs, input int sc, input int w, input bit mr);
    hstart     = 10'(hs);
    hscale     = 8'(sc);
    line_width = 10'(w);
    mirror     = mr;
    line_start = 1'b1;
    n_starts++;
    tick();
    line_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int d0;
    d0 = done_count;
    for (int i = 0; i < budget; i++) begin
      if (done_count != d0) break;
      tick();
    end
    check(name, done_count - d0, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sel"},   active_render_buffer, 0);
    check({tag, "_idx"},   composer_rd_idx, 0);
    check({tag, "_valid"}, pix_valid, 0);
    check({tag, "_data"},  pix_data, 0);
    check({tag, "_done"},  line_done, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    tick();
    rst_n = 1'b1;
    tick();

    // Unity scale from index 0
    start_line(0, 128, 4, 0);
    @(negedge clk); check("t1_idx0", composer_rd_idx, 0);
    @(negedge clk); check("t1_idx1", composer_rd_idx, 1);
    @(negedge clk); check("t1_idx2", composer_rd_idx, 2);
    check("t1_first_valid", pix_valid, 1);
    check("t1_px0", pix_data, 8'd11);
    @(negedge clk); check("t1_idx3", composer_rd_idx, 3);
    check("t1_px1", pix_data, 8'd48);
    @(negedge clk);
    @(negedge clk); check("t1_done", line_done, 1);
    check("t1_px3", pix_data, 8'd122);
    @(negedge clk); check("t1_after_valid", pix_valid, 0);
    tick();

    // Half scale repeats each index
    start_line(10, 64, 4, 0);
    @(negedge clk); check("t2_idx0", composer_rd_idx, 10);
    @(negedge clk); check("t2_idx1", composer_rd_idx, 10);
    @(negedge clk); check("t2_idx2", composer_rd_idx, 11);
    check("t2_px0", pix_data, 8'd125);
    @(negedge clk); check("t2_idx3", composer_rd_idx, 11);
    @(negedge clk); check("t2_px2", pix_data, 8'd162);
    tick();
    wait_done(20, "t2_done");

    // Crossing the end of valid buffer range
    start_line(766, 128, 4, 0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); check("t3_idx2", composer_rd_idx, 768);
    check("t3_px0", pix_data, 8'd193);
    @(negedge clk); check("t3_px1", pix_data, 8'd230);
    @(negedge clk); check("t3_px2_valid", pix_valid, 1);
    check("t3_px2_zero", pix_data, 0);
    tick();
    wait_done(20, "t3_done");

    // line_start arriving in the same cycle as line_done
    start_line(20, 128, 2, 0);
    tick(); tick(); tick();
    hstart = 10'd30; hscale = 8'd128; line_width = 10'd2; line_start = 1'b1;
    n_starts++;
    @(negedge clk); check("t7_done_wins", line_done, 1);
    tick();
    line_start = 1'b0;
    wait_done(20, "t7_restart_done");

    // Long line with random backpressure, scaled past the valid range
    start_line(100, 150, 640, 0);
    d0 = done_count;
    for (int i = 0; i < 4000; i++) begin
      if (done_count != d0) break;
      pix_ready = 1'($urandom_range(0, 1));
      tick();
    end
    pix_ready = 1'b1;
    check("t4_done", done_count - d0, 1);
    check("t4_count", accepted, 640);
    tick();

    // Abort mid-line
    start_line(0, 128, 300, 0);
    for (int i = 0; i < 500; i++) begin
      if (accepted >= 100) break;
      tick();
    end
    check("t5_reached_100", accepted >= 100, 1);
    d0 = done_count;
    start_line(200, 128, 8, 0);
    @(negedge clk);
    check("t5_flushed", pix_valid, 0);
    check("t5_sel", active_render_buffer, n_starts % 2);
    for (int i = 0; i < 10; i++) begin
      if (pix_valid) break;
      @(negedge clk);
    end
    check("t5_new_first", pix_data, 8'd243);
    tick();
    wait_done(30, "t5_new_done");
    check("t5_no_abort_done", done_count - d0, 1);

`ifdef LINE_READER_MIRROR_EN
    start_line(5, 128, 3, 1);
    @(negedge clk); check("mir_idx0", composer_rd_idx, 5);
    @(negedge clk); check("mir_idx1", composer_rd_idx, 4);
    @(negedge clk); check("mir_idx2", composer_rd_idx, 3);
    tick();
    wait_done(20, "mir_done");
`endif

    // Reset mid-line
    start_line(40, 128, 50, 0);
    repeat (10) tick();
    rst_n = 1'b0;
    tick();
    check_reset_outputs("t6");
    n_starts = 0;
    rst_n = 1'b1;
    tick();
    tick();
    start_line(0, 128, 2, 0);
    wait_done(20, "t6_after_reset_done");

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
